// File: rtl/manchester_tx_frame.sv
// Manchester frame transmitter: optional turn-on lead and preamble, then DATA_WIDTH
// Manchester-coded data bits, with back-to-back words over a valid/ready handshake.
module manchester_tx_frame #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          HALF_BIT_CYCLES = 1,
  parameter int          PREAMBLE_BITS   = 0,
  parameter logic [15:0] PREAMBLE        = 16'h0000,
  parameter int          LEAD_CYCLES     = 1,
  parameter bit          LSB_FIRST       = 1'b0,
  parameter bit          IEEE_MODE       = 1'b0
) (
  input  logic                  clk2x,
  input  logic                  rst,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_on,
  output logic                  busy,
  output logic                  done
);

  // state  | meaning
  // S_IDLE | line released, waiting for a word
  // S_LEAD | dout_on high, dout low
  // S_PRE  | preamble bits
  // S_DATA | data bits; bit count == DATA_WIDTH is the end/handover slot
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_PRE, S_DATA} state_t;

  localparam int HW = $clog2(HALF_BIT_CYCLES) + 1;
  localparam int BW = $clog2(DATA_WIDTH + PREAMBLE_BITS) + 1;
  localparam int LW = $clog2(LEAD_CYCLES + 1) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_BIT_CYCLES - 1);
  localparam logic [BW-1:0] P_LAST = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] D_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] D_END  = BW'(DATA_WIDTH);
  localparam logic [LW-1:0] L_LAST = LW'(LEAD_CYCLES - 1);
  localparam logic [15:0]   PRE_ALIGNED = PREAMBLE << (16 - PREAMBLE_BITS);

  state_t                r_state, w_state_nxt;
  logic [HW-1:0]         r_hcnt, w_hcnt_nxt, w_hcnt;
  logic [BW-1:0]         r_bcnt, w_bcnt_nxt, w_bcnt;
  logic [LW-1:0]         r_lcnt, w_lcnt_nxt;
  logic                  r_half, w_half_nxt, w_half;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt, w_word;
  logic                  r_ready, w_ready_nxt;
  logic                  r_dout, w_dout_nxt;
  logic                  r_on, w_on_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_accept, w_bypass, w_hdone, w_bdone, w_dbit, w_pbit;

  // Registers hold what the line shows now; the state holds the slot shown next edge.
  always_ff @(posedge clk2x or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_lcnt  <= '0;
      r_half  <= 1'b0;
      r_shift <= '0;
      r_ready <= 1'b0;
      r_dout  <= 1'b0;
      r_on    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_half  <= w_half_nxt;
      r_shift <= w_shift_nxt;
      r_ready <= w_ready_nxt;
      r_dout  <= w_dout_nxt;
      r_on    <= w_on_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A word taken in the handover slot starts at bit 0, first half, straight from din.
  assign w_accept = din_valid & r_ready;
  assign w_bypass = (r_state == S_DATA) && (r_bcnt == D_END) && w_accept;
  assign w_word   = w_bypass ? din : r_shift;
  assign w_hcnt   = w_bypass ? '0 : r_hcnt;
  assign w_bcnt   = w_bypass ? '0 : r_bcnt;
  assign w_half   = w_bypass ? 1'b0 : r_half;
  assign w_dbit   = LSB_FIRST ? w_word[0] : w_word[DATA_WIDTH-1];
  assign w_pbit   = PRE_ALIGNED[4'(4'd15 - 4'(w_bcnt))];
  assign w_hdone  = (w_hcnt == H_LAST);
  assign w_bdone  = w_hdone & w_half;

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_bcnt_nxt  = r_bcnt;
    w_lcnt_nxt  = r_lcnt;
    w_half_nxt  = r_half;
    w_shift_nxt = r_shift;
    w_ready_nxt = r_ready;
    w_dout_nxt  = 1'b0;
    w_on_nxt    = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (w_accept) begin
          w_shift_nxt = din;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_hcnt_nxt  = '0;
          w_bcnt_nxt  = '0;
          w_lcnt_nxt  = '0;
          w_half_nxt  = 1'b0;
          if (LEAD_CYCLES > 0)        w_state_nxt = S_LEAD;
          else if (PREAMBLE_BITS > 0) w_state_nxt = S_PRE;
          else                        w_state_nxt = S_DATA;
        end
      end
      S_LEAD: begin
        w_on_nxt   = 1'b1;
        w_lcnt_nxt = r_lcnt + LW'(1);
        if (r_lcnt == L_LAST) begin
          w_lcnt_nxt  = '0;
          w_state_nxt = (PREAMBLE_BITS > 0) ? S_PRE : S_DATA;
        end
      end
      S_PRE: begin
        w_on_nxt   = 1'b1;
        w_dout_nxt = w_pbit ^ w_half ^ IEEE_MODE;
        w_hcnt_nxt = w_hdone ? '0 : w_hcnt + HW'(1);
        w_half_nxt = w_hdone ? ~w_half : w_half;
        if (w_bdone) begin
          if (w_bcnt == P_LAST) begin
            w_bcnt_nxt  = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_bcnt_nxt = w_bcnt + BW'(1);
          end
        end
      end
      S_DATA: begin
        if ((r_bcnt == D_END) && !w_accept) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
          w_bcnt_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_on_nxt   = 1'b1;
          w_dout_nxt = w_dbit ^ w_half ^ IEEE_MODE;
          w_hcnt_nxt = w_hdone ? '0 : w_hcnt + HW'(1);
          w_half_nxt = w_hdone ? ~w_half : w_half;
          w_bcnt_nxt = w_bcnt;
          if (w_bypass) begin
            w_ready_nxt = 1'b0;
            w_shift_nxt = din;
          end
          if (w_bdone) begin
            w_shift_nxt = LSB_FIRST ? (w_word >> 1) : (w_word << 1);
            w_bcnt_nxt  = w_bcnt + BW'(1);
            if (w_bcnt == D_LAST) w_ready_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign din_ready = r_ready;
  assign dout      = r_dout;
  assign dout_on   = r_on;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/manchester_tx_frame.md
# manchester_tx_frame

Parametrised Manchester frame transmitter, the successor to the fixed 8-bit encoder on the trigger/data line. It accepts words over a valid/ready handshake and emits an optional preamble followed by the data bits, Manchester-coded. Both the bit rate (clk2x cycles per half-bit) and the coding convention are configurable. It supports back-to-back words with no gap. It drives the tristate-enable (`dout_on`) with a configurable turn-on lead and reports frame completion.

## Interface
- `DATA_WIDTH`, 8: bits per word; must be ≥ 2.
- `HALF_BIT_CYCLES`, 1: clk2x cycles per half-bit; must be ≥ 1.
- `PREAMBLE_BITS`, 0: preamble length in bits, 0 to 16; 0 means no preamble.
- `PREAMBLE`, 16'h0000: preamble pattern; the low `PREAMBLE_BITS` bits are sent MSB-first.
- `LEAD_CYCLES`, 1: clk2x cycles for which `dout_on` is high with `dout`=0 before the first half-bit; may be 0.
- `LSB_FIRST`, 0: 1 sends data bits LSB-first, 0 sends them MSB-first.
- `IEEE_MODE`, 0: 0 selects G.E. Thomas coding (bit b → halves b, ~b); 1 selects IEEE 802.3 coding (bit b → halves ~b, b).
- `clk2x` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `din_valid` input 1: word available.
- `din` input DATA_WIDTH: word; captured on the accepting edge only.
- `din_ready` output 1: registered; a word is accepted on any edge where `din_valid & din_ready`.
- `dout` output 1: registered Manchester line data.
- `dout_on` output 1: registered tristate enable.
- `busy` output 1: registered; high from the accept edge until the frame ends.
- `done` output 1: registered one-cycle pulse at the end of a frame.

## Operation
- States: IDLE, LEAD, PRE, DATA.
- IDLE: `din_ready`=1, `dout`=0, `dout_on`=0. On accept, latch `din` into the shift register and go to LEAD. If `LEAD_CYCLES`=0, skip LEAD and go to PRE; if `PREAMBLE_BITS`=0, skip PRE and go to DATA.
- LEAD: `dout_on`=1 and `dout`=0 for `LEAD_CYCLES` cycles.
- PRE: send each preamble bit as two half-bits in the selected coding, MSB-first.
- DATA: send `DATA_WIDTH` bits in the selected coding and order. Each half-bit level holds for `HALF_BIT_CYCLES` cycles.
- Back-to-back: `din_ready` is high in DATA only for the one cycle during which `dout` shows the final cycle of the last half-bit.
  - If a word is accepted on that edge, the next edge shows its first data half-bit, with no lead, no preamble and no `done`. `dout_on` stays high and `din_ready` drops.
  - If no word is accepted, the next edge gives `dout`=0, `dout_on`=0, `busy`=0 and `done`=1, and the block returns to IDLE with `din_ready` remaining 1.
- `din_valid` and `din` are ignored whenever `din_ready`=0. Changes to `din` after acceptance do not affect the frame in flight.
- Counters:
  - Half-bit cycle counter: clogb2(HALF_BIT_CYCLES)+1 bits.
  - Bit counter: clogb2(DATA_WIDTH+PREAMBLE_BITS)+1 bits.
  - Both are cleared on entering each state and must never wrap mid-state.
- Reset: asynchronous. All outputs go to 0 immediately, the state goes to IDLE and the shift register clears. The frame in flight is abandoned with no `done`. `din_ready` rises on the first edge after `rst` deasserts.

## Timing
Accept edge E0 (defaults: `LEAD_CYCLES`=1, `HALF_BIT_CYCLES`=1, `PREAMBLE_BITS`=0, `DATA_WIDTH`=8):
- E0: `busy`=1, `din_ready`=0.
- E1: `dout_on`=1, `dout`=0 (lead).
- E2–E17: the 16 half-bits.
- After E17: `din_ready`=1.
- E18: either `done`=1 with `dout_on`=0, or the first half-bit of the next word.

General frame length, `dout_on` high from E1: L = `LEAD_CYCLES` + 2·`HALF_BIT_CYCLES`·(`PREAMBLE_BITS`+`DATA_WIDTH`) cycles. `done` is asserted at edge E(L+1).

## Test plan
- Defaults, `din`=8'hA5, held for one accept → `dout` on E2..E17 = 1,0,0,1,1,0,0,1,0,1,1,0,0,1,1,0. `dout_on` is high exactly 17 cycles. A single `done` at E18.
- `IEEE_MODE`=1, `LSB_FIRST`=1, `din`=8'h01 → half-bits 0,1 then seven pairs of 1,0. `done` at E18.
- Back-to-back: 8'hFF then 8'h00, with `din_valid` held → `dout_on` continuously high for 33 cycles (E1..E33). Half-bits are eight pairs of 1,0 then eight pairs of 0,1. Exactly one `done`, at E34.
- `HALF_BIT_CYCLES`=3, `PREAMBLE_BITS`=4, `PREAMBLE`=4'b1010, `din`=8'h00 → every level held 3 cycles. Preamble half-bits are 1,0,0,1,1,0,0,1. `dout_on` is high for 73 cycles and `done` fires 74 cycles after the accept edge.
- Assert `rst` mid-DATA after three bits → `dout`, `dout_on`, `busy` and `din_ready` go to 0 without a clock edge, and no `done` is produced. After release, `din_ready`=1 on the first edge, and the next frame matches scenario 1.
- While busy, toggle `din_valid` and change `din` to 8'hFF → no accept occurs and the frame in flight is unchanged. `din_ready` is high only in the final half-bit cycle.
